// File: rtl/cpu_pkg.sv
// Shared datapath definitions: default word width and operand-stage occupancy encodings.
// No logic of its own; constants and a small helper only.
// Occupancy is derived from the main/skid valid bits, never stored separately.
package cpu_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    // The skid register is only ever filled while main is full, so skid_v alone means TWO.
    function automatic occ_t occ_of(input logic main_v, input logic skid_v);
        occ_t occ;
        if (skid_v) begin
            occ = OCC_TWO;
        end else if (main_v) begin
            occ = OCC_ONE;
        end else begin
            occ = OCC_EMPTY;
        end
        return occ;
    endfunction

endpackage

// File: rtl/mux_nto1.sv
// Combinational NUM_IN:1 word selector with zero output and error flag on out-of-range select.
// Latency: 0 cycles (purely combinational).
// No handshake; the enclosing stage owns flow control.
module mux_nto1 #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    range_err
);

    // Pick the addressed word; a select past the last input yields all-zero and raises range_err.
    always_comb begin
        out_data  = '0;
        range_err = (32'(sel) >= 32'(NUM_IN));
        for (int i = 0; i < NUM_IN; i++) begin
            if (32'(sel) == 32'(i)) begin
                out_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/pipe_mux_reg.sv
// Registered N:1 operand select stage with valid/ready on both sides and a 2-entry skid buffer.
// Latency: 1 cycle accept-to-out_valid; sustains 1 word/cycle while out_ready is high.
// Backpressure: in_ready is registered (low only while the skid holds a word), never combinational on out_ready.
module pipe_mux_reg
    import cpu_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int NUM_IN = 4,
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    flush,
    output logic                    sel_err
);

    logic [WIDTH-1:0] word;
    logic             word_err;
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             accept;
    logic             xfer;
    occ_t             occ;

    mux_nto1 #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux (
        .in_data   (in_data),
        .sel       (in_sel),
        .out_data  (word),
        .range_err (word_err)
    );

    assign in_ready = !skid_valid;
    assign accept   = in_valid & in_ready;
    assign xfer     = out_valid & out_ready;
    assign occ      = occ_of(out_valid, skid_valid);

    // Main/skid occupancy update; flush drops everything in flight but leaves out_data as-is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            sel_err    <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            if (accept && word_err) begin
                sel_err <= 1'b1;
            end
            case (occ)
                // Input is blocked in TWO, so a transfer just promotes the skid word.
                OCC_TWO: begin
                    if (xfer) begin
                        out_data   <= skid_data;
                        skid_valid <= 1'b0;
                    end
                end
                OCC_ONE: begin
                    if (xfer) begin
                        out_valid <= accept;
                        if (accept) begin
                            out_data <= word;
                        end
                    end else if (accept) begin
                        skid_data  <= word;
                        skid_valid <= 1'b1;
                    end
                end
                default: begin
                    out_valid <= accept;
                    if (accept) begin
                        out_data <= word;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_mux_reg.sv
module tb_pipe_mux_reg;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // NUM_IN=4, WIDTH=32 instance for directed handshake tests
    logic [127:0] in_data4 = '0;
    logic [1:0]   in_sel4 = '0;
    logic         in_valid4 = 1'b0, out_ready4 = 1'b0, flush4 = 1'b0;
    logic         in_ready4, out_valid4, sel_err4;
    logic [31:0]  out_data4;
    logic [31:0]  q4[$];

    // NUM_IN=3 instance for out-of-range select
    logic [95:0]  in_data3 = '0;
    logic [1:0]   in_sel3 = '0;
    logic         in_valid3 = 1'b0, out_ready3 = 1'b0, flush3 = 1'b0;
    logic         in_ready3, out_valid3, sel_err3;
    logic [31:0]  out_data3;

    // NUM_IN=5, WIDTH=8 instance for random scoreboard
    logic [39:0]  in_data5 = '0;
    logic [2:0]   in_sel5 = '0;
    logic         in_valid5 = 1'b0, out_ready5 = 1'b0, flush5 = 1'b0;
    logic         in_ready5, out_valid5, sel_err5;
    logic [7:0]   out_data5;
    logic [7:0]   q5[$];

    pipe_mux_reg #(.WIDTH(32), .NUM_IN(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_sel(in_sel4),
        .in_valid(in_valid4), .in_ready(in_ready4), .out_data(out_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .flush(flush4), .sel_err(sel_err4)
    );

    pipe_mux_reg #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_sel(in_sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .flush(flush3), .sel_err(sel_err3)
    );

    pipe_mux_reg #(.WIDTH(8), .NUM_IN(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_sel(in_sel5),
        .in_valid(in_valid5), .in_ready(in_ready5), .out_data(out_data5),
        .out_valid(out_valid5), .out_ready(out_ready5), .flush(flush5), .sel_err(sel_err5)
    );

    // Scoreboard for the 4-input instance: every transfer must match the oldest accepted word.
    always @(negedge clk) begin
        if (rst_n && !flush4 && out_valid4 && out_ready4) begin
            tests = tests + 1;
            if (q4.size() == 0) begin
                fails = fails + 1;
                $display("FAIL sb4_spurious: transfer of %h with no word expected", out_data4);
            end else begin
                logic [31:0] exp4;
                exp4 = q4.pop_front();
                if (out_data4 !== exp4) begin
                    fails = fails + 1;
                    $display("FAIL sb4_data: got %h expected %h", out_data4, exp4);
                end
            end
        end
    end

    // Scoreboard for the 5-input random instance.
    always @(negedge clk) begin
        if (rst_n && !flush5 && out_valid5 && out_ready5) begin
            tests = tests + 1;
            if (q5.size() == 0) begin
                fails = fails + 1;
                $display("FAIL sb5_spurious: transfer of %h with no word expected", out_data5);
            end else begin
                logic [7:0] exp5;
                exp5 = q5.pop_front();
                if (out_data5 !== exp5) begin
                    fails = fails + 1;
                    $display("FAIL sb5_data: got %h expected %h", out_data5, exp5);
                end
            end
        end
    end

    // Drive the 4-input instance just after an edge; log the word if it will be accepted.
    task automatic drive4(input logic v, input int sel, input logic ordy, input logic fl);
        in_valid4  = v;
        in_sel4    = 2'(sel);
        out_ready4 = ordy;
        flush4     = fl;
        if (fl) begin
            q4.delete();
        end else if (v && in_ready4) begin
            q4.push_back(in_data4[sel*32 +: 32]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests = tests + 1;
        if ({out_valid4, in_ready4, sel_err4} !== 3'b010 || out_data4 !== 32'h0) begin
            fails = fails + 1;
            $display("FAIL reset4: valid/ready/err=%b data=%h expected 010 and 0",
                     {out_valid4, in_ready4, sel_err4}, out_data4);
        end
        tests = tests + 1;
        if ({out_valid5, in_ready5, sel_err5} !== 3'b010 || out_data5 !== 8'h0) begin
            fails = fails + 1;
            $display("FAIL reset5: valid/ready/err=%b data=%h expected 010 and 0",
                     {out_valid5, in_ready5, sel_err5}, out_data5);
        end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        in_data4 = {32'h0000_00D3, 32'h0000_00C2, 32'h0000_00B1, 32'h0000_00A0};
        drive4(1'b1, 2, 1'b1, 1'b0);
        tick();
        tests = tests + 1;
        if (out_valid4 !== 1'b1 || out_data4 !== 32'hC2) begin
            fails = fails + 1;
            $display("FAIL basic_latency: valid=%b data=%h expected 1 and 000000c2", out_valid4, out_data4);
        end
        for (int s = 0; s < 4; s++) begin
            drive4(1'b1, s, 1'b1, 1'b0);
            tick();
            tests = tests + 1;
            if (out_valid4 !== 1'b1 || in_ready4 !== 1'b1) begin
                fails = fails + 1;
                $display("FAIL basic_stream%0d: valid=%b ready=%b expected 1 1", s, out_valid4, in_ready4);
            end
        end
        drive4(1'b0, 0, 1'b1, 1'b0);
        tick();
        tests = tests + 1;
        if (out_valid4 !== 1'b0 || q4.size() != 0) begin
            fails = fails + 1;
            $display("FAIL basic_drain: valid=%b pending=%0d expected 0 0", out_valid4, q4.size());
        end
    endtask

    task automatic test_stall();
        drive4(1'b1, 1, 1'b0, 1'b0);
        tick();
        drive4(1'b1, 3, 1'b0, 1'b0);
        tick();
        tests = tests + 1;
        if (out_data4 !== 32'hB1 || out_valid4 !== 1'b1 || in_ready4 !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL stall_two: data=%h valid=%b ready=%b expected b1 1 0", out_data4, out_valid4, in_ready4);
        end
        drive4(1'b1, 0, 1'b0, 1'b0);
        tick();
        tests = tests + 1;
        if (out_data4 !== 32'hB1 || in_ready4 !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL stall_hold: data=%h ready=%b expected b1 0", out_data4, in_ready4);
        end
        drive4(1'b0, 0, 1'b1, 1'b0);
        tick();
        tests = tests + 1;
        if (out_data4 !== 32'hD3 || out_valid4 !== 1'b1 || in_ready4 !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL stall_release: data=%h valid=%b ready=%b expected d3 1 1", out_data4, out_valid4, in_ready4);
        end
        drive4(1'b0, 0, 1'b1, 1'b0);
        tick();
        tests = tests + 1;
        if (out_valid4 !== 1'b0 || q4.size() != 0) begin
            fails = fails + 1;
            $display("FAIL stall_drain: valid=%b pending=%0d expected 0 0", out_valid4, q4.size());
        end
    endtask

    task automatic test_sel_err();
        logic [31:0] exp_d [4] = '{32'h33, 32'h0, 32'h22, 32'h11};
        logic        exp_e [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        int          sels  [4] = '{2, 3, 1, 0};
        in_data3   = {32'h33, 32'h22, 32'h11};
        out_ready3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid3 = 1'b1;
            in_sel3   = 2'(sels[k]);
            tick();
            tests = tests + 1;
            if (out_valid3 !== 1'b1 || out_data3 !== exp_d[k] || sel_err3 !== exp_e[k]) begin
                fails = fails + 1;
                $display("FAIL sel_err_step%0d: valid=%b data=%h err=%b expected 1 %h %b",
                         k, out_valid3, out_data3, sel_err3, exp_d[k], exp_e[k]);
            end
        end
        in_valid3 = 1'b0;
        flush3    = 1'b1;
        tick();
        flush3 = 1'b0;
        tests = tests + 1;
        if (sel_err3 !== 1'b0 || out_valid3 !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL sel_err_flush: err=%b valid=%b expected 0 0", sel_err3, out_valid3);
        end
    endtask

    task automatic test_flush();
        drive4(1'b1, 0, 1'b0, 1'b0);
        tick();
        drive4(1'b1, 1, 1'b0, 1'b0);
        tick();
        tests = tests + 1;
        if (in_ready4 !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL flush_two: ready=%b expected 0", in_ready4);
        end
        drive4(1'b1, 2, 1'b0, 1'b1);
        tick();
        tests = tests + 1;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || sel_err4 !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL flush_from_two: valid=%b ready=%b err=%b expected 0 1 0", out_valid4, in_ready4, sel_err4);
        end
        drive4(1'b1, 3, 1'b0, 1'b0);
        tick();
        drive4(1'b1, 2, 1'b1, 1'b1);
        tick();
        tests = tests + 1;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL flush_from_one: valid=%b ready=%b expected 0 1", out_valid4, in_ready4);
        end
        for (int k = 0; k < 3; k++) begin
            drive4(1'b0, 0, 1'b1, 1'b0);
            tick();
            tests = tests + 1;
            if (out_valid4 !== 1'b0) begin
                fails = fails + 1;
                $display("FAIL flush_leak%0d: valid=%b data=%h expected valid 0", k, out_valid4, out_data4);
            end
        end
    endtask

    task automatic test_async_reset();
        drive4(1'b1, 3, 1'b0, 1'b0);
        tick();
        tests = tests + 1;
        if (out_valid4 !== 1'b1 || out_data4 !== 32'hD3) begin
            fails = fails + 1;
            $display("FAIL arst_setup: valid=%b data=%h expected 1 d3", out_valid4, out_data4);
        end
        drive4(1'b0, 0, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        tests = tests + 1;
        if (out_valid4 !== 1'b0 || out_data4 !== 32'h0 || in_ready4 !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL arst_immediate: valid=%b data=%h ready=%b expected 0 0 1", out_valid4, out_data4, in_ready4);
        end
        q4.delete();
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic exp_err = 1'b0;
        int   pushed = 0;
        for (int c = 0; c < 10000; c++) begin
            int sel;
            in_data5   = {8'($urandom), 32'($urandom)};
            sel        = $urandom_range(0, 7);
            in_sel5    = 3'(sel);
            in_valid5  = ($urandom_range(0, 3) != 0);
            out_ready5 = ($urandom_range(0, 2) != 0);
            if (in_valid5 && in_ready5) begin
                pushed = pushed + 1;
                if (sel < 5) begin
                    q5.push_back(in_data5[sel*8 +: 8]);
                end else begin
                    q5.push_back(8'h00);
                    exp_err = 1'b1;
                end
            end
            tick();
        end
        in_valid5  = 1'b0;
        out_ready5 = 1'b1;
        for (int k = 0; k < 10 && q5.size() != 0; k++) begin
            tick();
        end
        tick();
        tests = tests + 1;
        if (q5.size() != 0 || out_valid5 !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL random_drain: pending=%0d valid=%b expected 0 0 (accepted %0d)", q5.size(), out_valid5, pushed);
        end
        tests = tests + 1;
        if (sel_err5 !== exp_err) begin
            fails = fails + 1;
            $display("FAIL random_sel_err: err=%b expected %b", sel_err5, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_sel_err();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
